// File: rtl/dsp48a1.sv
// dsp48a1: Spartan-6 style DSP slice: 18-bit pre-adder, 18x18 multiplier, 48-bit post-adder with cascade.
// Optional macro DSP48A1_SIGNED_MULT_EN: two's-complement multiplier with M sign-extended into X.

// Pipeline register with bypass; RST_N beats the stage clear, which beats the clock enable.
// Latency: one edge when EN=1, zero when EN=0.
// No backpressure; CE low holds the stored value.
module dsp48a1_reg #(
  parameter int    W       = 18,
  parameter int    EN      = 1,
  parameter string RSTTYPE = "SYNC"
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rst,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (EN == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n, rst, ce};
    assign q = d;
  end else if (RSTTYPE == "ASYNC") begin : g_async
    always_ff @(posedge clk or negedge rst_n or posedge rst) begin
      if (!rst_n)   q <= '0;
      else if (rst) q <= '0;
      else if (ce)  q <= d;
    end
  end else begin : g_sync
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   q <= '0;
      else if (rst) q <= '0;
      else if (ce)  q <= d;
    end
  end
endmodule

// DSP slice top: operand stages, pre-adder, multiplier, X/Z muxes, post-adder and P/carry-out stages.
// Latency (defaults): A/B to P 3 edges, D to P 4 edges, OPMODE to effect 1 edge.
// No backpressure; each stage stalls only through its own clock enable.
module dsp48a1 #(
  parameter int    WIDTH_A     = 18,
  parameter int    WIDTH_C     = 48,
  parameter int    WIDTH_OP    = 8,
  parameter int    WIDTH_M     = 36,
  parameter int    WIDTH_CARRY = 1,
  parameter int    A0REG       = 0,
  parameter int    B0REG       = 0,
  parameter int    A1REG       = 1,
  parameter int    B1REG       = 1,
  parameter int    CREG        = 1,
  parameter int    DREG        = 1,
  parameter int    MREG        = 1,
  parameter int    PREG        = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter int    OPMODEREG   = 1,
  parameter string CARRYINSEL  = "OPMODE5",
  parameter string B_INPUT     = "DIRECT",
  parameter string RSTTYPE     = "SYNC"
) (
  input  logic [WIDTH_A-1:0]  A,
  input  logic [WIDTH_A-1:0]  B,
  input  logic [WIDTH_C-1:0]  C,
  input  logic [WIDTH_A-1:0]  D,
  input  logic                CLK,
  input  logic                CARRYIN,
  input  logic [WIDTH_OP-1:0] OPMODE,
  input  logic [WIDTH_A-1:0]  BCIN,
  input  logic                RSTA,
  input  logic                RSTB,
  input  logic                RSTM,
  input  logic                RSTP,
  input  logic                RSTC,
  input  logic                RSTD,
  input  logic                RSTCARRYIN,
  input  logic                RSTOPMODE,
  input  logic                CEA,
  input  logic                CEB,
  input  logic                CEM,
  input  logic                CEP,
  input  logic                CEC,
  input  logic                CED,
  input  logic                CECARRYIN,
  input  logic                COPMODE,
  input  logic [WIDTH_C-1:0]  PCIN,
  output logic [WIDTH_A-1:0]  BCOUT,
  output logic [WIDTH_C-1:0]  PCOUT,
  output logic [WIDTH_C-1:0]  P,
  output logic [WIDTH_M-1:0]  M,
  output logic                CARRYOUT,
  output logic                CARRYOUTF,
  input  logic                RST_N
);
  logic [WIDTH_A-1:0]     a0, a1, b_src, b0, b1_in, b1, d, pre;
  logic [WIDTH_C-1:0]     c, x, z, m_ext, p;
  logic [WIDTH_OP-1:0]    op;
  logic [WIDTH_M-1:0]     m_in, m;
  logic [WIDTH_CARRY-1:0] cin_in, cin, cout;
  logic [WIDTH_C:0]       post;

  assign b_src = (B_INPUT == "CASCADE") ? BCIN : B;

  dsp48a1_reg #(.W(WIDTH_A),  .EN(A0REG),     .RSTTYPE(RSTTYPE)) u_a0  (.clk(CLK), .rst_n(RST_N), .rst(RSTA),      .ce(CEA),     .d(A),      .q(a0));
  dsp48a1_reg #(.W(WIDTH_A),  .EN(A1REG),     .RSTTYPE(RSTTYPE)) u_a1  (.clk(CLK), .rst_n(RST_N), .rst(RSTA),      .ce(CEA),     .d(a0),     .q(a1));
  dsp48a1_reg #(.W(WIDTH_A),  .EN(B0REG),     .RSTTYPE(RSTTYPE)) u_b0  (.clk(CLK), .rst_n(RST_N), .rst(RSTB),      .ce(CEB),     .d(b_src),  .q(b0));
  dsp48a1_reg #(.W(WIDTH_A),  .EN(B1REG),     .RSTTYPE(RSTTYPE)) u_b1  (.clk(CLK), .rst_n(RST_N), .rst(RSTB),      .ce(CEB),     .d(b1_in),  .q(b1));
  dsp48a1_reg #(.W(WIDTH_A),  .EN(DREG),      .RSTTYPE(RSTTYPE)) u_d   (.clk(CLK), .rst_n(RST_N), .rst(RSTD),      .ce(CED),     .d(D),      .q(d));
  dsp48a1_reg #(.W(WIDTH_C),  .EN(CREG),      .RSTTYPE(RSTTYPE)) u_c   (.clk(CLK), .rst_n(RST_N), .rst(RSTC),      .ce(CEC),     .d(C),      .q(c));
  dsp48a1_reg #(.W(WIDTH_OP), .EN(OPMODEREG), .RSTTYPE(RSTTYPE)) u_op  (.clk(CLK), .rst_n(RST_N), .rst(RSTOPMODE), .ce(COPMODE), .d(OPMODE), .q(op));

  // Pre-adder result replaces b0 on its way into B1 only when op[4] asks for it.
  assign pre   = op[6] ? d - b0 : d + b0;
  assign b1_in = op[4] ? pre : b0;
  assign BCOUT = b1;

`ifdef DSP48A1_SIGNED_MULT_EN
  assign m_in  = {{(WIDTH_M-WIDTH_A){a1[WIDTH_A-1]}}, a1} * {{(WIDTH_M-WIDTH_A){b1[WIDTH_A-1]}}, b1};
  assign m_ext = {{(WIDTH_C-WIDTH_M){m[WIDTH_M-1]}}, m};
`else
  assign m_in  = {{(WIDTH_M-WIDTH_A){1'b0}}, a1} * {{(WIDTH_M-WIDTH_A){1'b0}}, b1};
  assign m_ext = {{(WIDTH_C-WIDTH_M){1'b0}}, m};
`endif

  dsp48a1_reg #(.W(WIDTH_M), .EN(MREG), .RSTTYPE(RSTTYPE)) u_m (.clk(CLK), .rst_n(RST_N), .rst(RSTM), .ce(CEM), .d(m_in), .q(m));
  assign M = m;

  always_comb begin
    case (op[1:0])
      2'd0:    x = '0;
      2'd1:    x = m_ext;
      2'd2:    x = p;
      default: x = {d[WIDTH_C-2*WIDTH_A-1:0], a1, b1};
    endcase
  end

  always_comb begin
    case (op[3:2])
      2'd0:    z = '0;
      2'd1:    z = PCIN;
      2'd2:    z = p;
      default: z = c;
    endcase
  end

  assign cin_in = (CARRYINSEL == "CARRYIN") ? CARRYIN : op[5];
  dsp48a1_reg #(.W(WIDTH_CARRY), .EN(CARRYINREG), .RSTTYPE(RSTTYPE)) u_cin (.clk(CLK), .rst_n(RST_N), .rst(RSTCARRYIN), .ce(CECARRYIN), .d(cin_in), .q(cin));

  // One extra bit so the carry/borrow out of the 48-bit sum lands in post[WIDTH_C].
  always_comb begin
    if (op[7]) post = {1'b0, z} - ({1'b0, x} + {{WIDTH_C{1'b0}}, cin});
    else       post = {1'b0, z} + {1'b0, x} + {{WIDTH_C{1'b0}}, cin};
  end

  dsp48a1_reg #(.W(WIDTH_C),     .EN(PREG),        .RSTTYPE(RSTTYPE)) u_p    (.clk(CLK), .rst_n(RST_N), .rst(RSTP),       .ce(CEP),       .d(post[WIDTH_C-1:0]), .q(p));
  dsp48a1_reg #(.W(WIDTH_CARRY), .EN(CARRYOUTREG), .RSTTYPE(RSTTYPE)) u_cout (.clk(CLK), .rst_n(RST_N), .rst(RSTCARRYIN), .ce(CECARRYIN), .d(post[WIDTH_C]),     .q(cout));

  assign P         = p;
  assign PCOUT     = p;
  assign CARRYOUT  = cout;
  assign CARRYOUTF = cout;
endmodule

// File: tb/tb_dsp48a1.sv
// Self-checking bench for dsp48a1: directed sequences, a steady-state vector table and random traffic vs a reference model.
module tb_dsp48a1;
  logic [17:0] A, B, D, BCIN;
  logic [47:0] C, PCIN;
  logic [7:0]  OPMODE;
  logic CARRYIN, RST_N;
  logic RSTA, RSTB, RSTM, RSTP, RSTC, RSTD, RSTCARRYIN, RSTOPMODE;
  logic CEA, CEB, CEM, CEP, CEC, CED, CECARRYIN, COPMODE;
  logic CLK = 1'b0;

  logic [17:0] BCOUT, c_bcout;
  logic [47:0] PCOUT, P, c_pcout, c_p;
  logic [35:0] M, c_m;
  logic CARRYOUT, CARRYOUTF, c_co, c_cof;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  dsp48a1 u_dut (
    .A(A), .B(B), .C(C), .D(D), .CLK(CLK), .CARRYIN(CARRYIN), .OPMODE(OPMODE), .BCIN(BCIN),
    .RSTA(RSTA), .RSTB(RSTB), .RSTM(RSTM), .RSTP(RSTP), .RSTC(RSTC), .RSTD(RSTD),
    .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE),
    .CEA(CEA), .CEB(CEB), .CEM(CEM), .CEP(CEP), .CEC(CEC), .CED(CED),
    .CECARRYIN(CECARRYIN), .COPMODE(COPMODE), .PCIN(PCIN),
    .BCOUT(BCOUT), .PCOUT(PCOUT), .P(P), .M(M), .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF),
    .RST_N(RST_N)
  );

  dsp48a1 #(.B_INPUT("CASCADE"), .CARRYINSEL("CARRYIN"), .RSTTYPE("ASYNC")) u_cas (
    .A(A), .B(B), .C(C), .D(D), .CLK(CLK), .CARRYIN(CARRYIN), .OPMODE(OPMODE), .BCIN(BCIN),
    .RSTA(RSTA), .RSTB(RSTB), .RSTM(RSTM), .RSTP(RSTP), .RSTC(RSTC), .RSTD(RSTD),
    .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE),
    .CEA(CEA), .CEB(CEB), .CEM(CEM), .CEP(CEP), .CEC(CEC), .CED(CED),
    .CECARRYIN(CECARRYIN), .COPMODE(COPMODE), .PCIN(PCIN),
    .BCOUT(c_bcout), .PCOUT(c_pcout), .P(c_p), .M(c_m), .CARRYOUT(c_co), .CARRYOUTF(c_cof),
    .RST_N(RST_N)
  );

  // Reference model state for u_dut (default parameters: A0/B0 bypassed, all other stages registered).
  logic [17:0] ra1, rb1, rd;
  logic [47:0] rc, rp;
  logic [35:0] rm;
  logic [7:0]  rop;
  logic        rcin, rcout;

  function automatic void model_reset();
    ra1 = '0; rb1 = '0; rd = '0; rc = '0; rp = '0; rm = '0; rop = '0; rcin = 1'b0; rcout = 1'b0;
  endfunction

  function automatic void model_step();
    longint pre, xv, zv, s, prod;
    logic [63:0] preu, su, produ;
    logic [17:0] b1in;
    pre  = rop[6] ? longint'(rd) - longint'(B) : longint'(rd) + longint'(B);
    preu = pre;
    b1in = rop[4] ? preu[17:0] : B;
    case (rop[1:0])
      2'd0:    xv = 0;
      2'd1:    xv = longint'(rm);
      2'd2:    xv = longint'(rp);
      default: xv = (longint'(rd % 4096) << 36) + (longint'(ra1) << 18) + longint'(rb1);
    endcase
    case (rop[3:2])
      2'd0:    zv = 0;
      2'd1:    zv = longint'(PCIN);
      2'd2:    zv = longint'(rp);
      default: zv = longint'(rc);
    endcase
    s     = rop[7] ? zv - (xv + longint'(rcin)) : zv + xv + longint'(rcin);
    su    = s;
    prod  = longint'(ra1) * longint'(rb1);
    produ = prod;
    if (RSTP) rp = '0; else if (CEP) rp = su[47:0];
    if (RSTCARRYIN) begin rcout = 1'b0; rcin = 1'b0; end
    else if (CECARRYIN) begin rcout = su[48]; rcin = rop[5]; end
    if (RSTM) rm = '0; else if (CEM) rm = produ[35:0];
    if (RSTB) rb1 = '0; else if (CEB) rb1 = b1in;
    if (RSTA) ra1 = '0; else if (CEA) ra1 = A;
    if (RSTD) rd = '0; else if (CED) rd = D;
    if (RSTC) rc = '0; else if (CEC) rc = C;
    if (RSTOPMODE) rop = '0; else if (COPMODE) rop = OPMODE;
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void chk_model();
    chk("mdl_p", P, rp);
    chk("mdl_pcout", PCOUT, rp);
    chk("mdl_m", M, rm);
    chk("mdl_bcout", BCOUT, rb1);
    chk("mdl_co", CARRYOUT, rcout);
    chk("mdl_cof", CARRYOUTF, rcout);
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    chk_model();
  endtask

  task automatic set_rst(input logic v);
    RSTA = v; RSTB = v; RSTM = v; RSTP = v; RSTC = v; RSTD = v; RSTCARRYIN = v; RSTOPMODE = v;
  endtask

  task automatic set_ce(input logic v);
    CEA = v; CEB = v; CEM = v; CEP = v; CEC = v; CED = v; CECARRYIN = v; COPMODE = v;
  endtask

  typedef struct {
    logic [17:0] a, b, d;
    logic [47:0] c, pcin;
    logic [7:0]  op;
    logic [17:0] bcout;
    logic [35:0] m;
    logic [47:0] p;
    logic        co;
  } vec_t;

  vec_t vt [8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            a     b      d        c                   pcin   op      bcout     m         p                    co
    vt[0] = '{18'd10, 18'd15,  18'd3,   48'd12,             48'd40,   8'h35, 18'd18,    36'd180,   48'd221,             1'b0};
    vt[1] = '{18'd3,  18'd7,   18'd5,   48'd100,            48'd0,    8'h0D, 18'd7,     36'd21,    48'd121,             1'b0};
    vt[2] = '{18'd3,  18'd7,   18'd5,   48'd100,            48'd0,    8'h8D, 18'd7,     36'd21,    48'd79,              1'b0};
    vt[3] = '{18'd3,  18'd7,   18'd5,   48'd10,             48'd0,    8'h8D, 18'd7,     36'd21,    48'hFFFF_FFFF_FFF5,  1'b1};
    vt[4] = '{18'd1,  18'd2,   18'h123, 48'd0,              48'd0,    8'h03, 18'd2,     36'd2,     48'h1230_0004_0002,  1'b0};
    vt[5] = '{18'd4,  18'd5,   18'd20,  48'd0,              48'd1000, 8'h55, 18'd15,    36'd60,    48'd1060,            1'b0};
    vt[6] = '{18'd2,  18'd9,   18'd0,   48'hFFFF_FFFF_FFFF, 48'd0,    8'h2C, 18'd9,     36'd18,    48'd0,               1'b1};
    vt[7] = '{18'd1,  18'd100, 18'd3,   48'd0,              48'd0,    8'h51, 18'h3FF9F, 36'h3FF9F, 48'h3FF9F,           1'b0};

    A = '0; B = '0; C = '0; D = '0; BCIN = '0; PCIN = '0; OPMODE = '0; CARRYIN = 1'b0;
    set_rst(1'b0); set_ce(1'b1);
    RST_N = 1'b0;
    model_reset();
    #1;
    chk("rst_p", P, 48'd0);
    chk("rst_pcout", PCOUT, 48'd0);
    chk("rst_m", M, 36'd0);
    chk("rst_bcout", BCOUT, 18'd0);
    chk("rst_co", CARRYOUT, 1'b0);
    chk("rst_cof", CARRYOUTF, 1'b0);
    #1;
    RST_N = 1'b1;

    // Hold every stage clear with live operands on the inputs.
    set_rst(1'b1);
    A = 18'd10; B = 18'd15; C = 48'd12; D = 18'd3; PCIN = 48'd40; OPMODE = 8'h35;
    repeat (10) begin
      tick();
      chk("clr_p", P, 48'd0);
      chk("clr_m", M, 36'd0);
      chk("clr_bcout", BCOUT, 18'd0);
      chk("clr_co", CARRYOUT, 1'b0);
    end

    set_rst(1'b0);
    tick(); chk("pipe_p0", P, 48'd0);
    tick(); chk("pipe_p1", P, 48'd40);
    tick(); chk("pipe_p2", P, 48'd191);
    tick(); chk("pipe_p3", P, 48'd221);
    tick(); chk("pipe_p4", P, 48'd221);
    chk("pipe_m", M, 36'd180);
    chk("pipe_bcout", BCOUT, 18'd18);
    chk("pipe_co", CARRYOUT, 1'b0);

    OPMODE = 8'h3E;
    tick(); chk("acc_p0", P, 48'd221);
    tick(); chk("acc_p1", P, 48'd234);
    tick(); chk("acc_p2", P, 48'd247);
    tick(); chk("acc_p3", P, 48'd260);

    CEP = 1'b0;
    repeat (3) begin
      tick(); chk("cep_hold", P, 48'd260);
    end
    CEP = 1'b1;
    tick(); chk("cep_res0", P, 48'd273);
    tick(); chk("cep_res1", P, 48'd286);

    // Drop RST_N between edges: outputs must clear before the next edge.
    #2 RST_N = 1'b0;
    #1;
    chk("arst_p", P, 48'd0);
    chk("arst_pcout", PCOUT, 48'd0);
    chk("arst_m", M, 36'd0);
    chk("arst_bcout", BCOUT, 18'd0);
    chk("arst_co", CARRYOUT, 1'b0);
    chk("arst_cof", CARRYOUTF, 1'b0);
    model_reset();
    #1 RST_N = 1'b1;

    for (int i = 0; i < 8; i++) begin
      A = vt[i].a; B = vt[i].b; D = vt[i].d; C = vt[i].c; PCIN = vt[i].pcin; OPMODE = vt[i].op;
      repeat (6) tick();
      chk("vec_bcout", BCOUT, vt[i].bcout);
      chk("vec_m", M, vt[i].m);
      chk("vec_p", P, vt[i].p);
      chk("vec_co", CARRYOUT, vt[i].co);
    end

    // Cascade slice: BCIN feeds the pre-adder, external CARRYIN feeds the carry.
    A = 18'd1; B = 18'd100; D = 18'd3; BCIN = 18'd100; C = '0; PCIN = '0; OPMODE = 8'h51; CARRYIN = 1'b1;
    repeat (6) tick();
    chk("cas_bcout", c_bcout, 18'h3FF9F);
    chk("cas_m", c_m, 36'h3FF9F);
    chk("cas_p", c_p, 48'h3FFA0);
    chk("cas_pcout", c_pcout, 48'h3FFA0);
    chk("cas_co", c_co, 1'b0);
    chk("cas_cof", c_cof, 1'b0);

    // A short RSTP pulse between edges clears the ASYNC slice at once but not the SYNC one.
    RSTP = 1'b1;
    #1;
    chk("async_rstp_cas", c_p, 48'd0);
    chk("async_rstp_dut", P, rp);
    #1 RSTP = 1'b0;
    tick();
    chk("async_rstp_recover", c_p, 48'h3FFA0);

    for (int i = 0; i < 1500; i++) begin
      A       = (i % 50 == 0) ? 18'h3FFFF : 18'($urandom);
      B       = (i % 70 == 0) ? 18'h3FFFF : 18'($urandom);
      D       = 18'($urandom);
      BCIN    = 18'($urandom);
      C       = {16'($urandom), 32'($urandom)};
      PCIN    = {16'($urandom), 32'($urandom)};
      OPMODE  = 8'($urandom);
      CARRYIN = 1'($urandom);
      RSTA = ($urandom_range(0, 15) == 0); RSTB = ($urandom_range(0, 15) == 0);
      RSTM = ($urandom_range(0, 15) == 0); RSTP = ($urandom_range(0, 15) == 0);
      RSTC = ($urandom_range(0, 15) == 0); RSTD = ($urandom_range(0, 15) == 0);
      RSTCARRYIN = ($urandom_range(0, 15) == 0); RSTOPMODE = ($urandom_range(0, 15) == 0);
      CEA = ($urandom_range(0, 7) != 0); CEB = ($urandom_range(0, 7) != 0);
      CEM = ($urandom_range(0, 7) != 0); CEP = ($urandom_range(0, 7) != 0);
      CEC = ($urandom_range(0, 7) != 0); CED = ($urandom_range(0, 7) != 0);
      CECARRYIN = ($urandom_range(0, 7) != 0); COPMODE = ($urandom_range(0, 7) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dsp48a1.md
# dsp48a1

Parameterised DSP slice modelled on the Spartan-6 DSP48A1. It provides an 18-bit pre-adder, an 18x18 multiplier and a 48-bit post-adder/accumulator with cascade ports. Every pipeline stage can be bypassed by a parameter. It sits in arithmetic datapaths (MAC, filters) and chains through BCOUT and PCOUT.

## Interface
- WIDTH_A, 18: width of A, B, D, BCIN, BCOUT.
- WIDTH_C, 48: width of C, PCIN, P, PCOUT.
- WIDTH_OP, 8: OPMODE width.
- WIDTH_M, 36: multiplier and M width.
- WIDTH_CARRY, 1: carry width.
- A0REG / B0REG, 0: input-stage register enables. 1 = registered, 0 = bypass (this meaning applies to every *REG parameter).
- A1REG, B1REG, CREG, DREG, MREG, PREG, CARRYINREG, CARRYOUTREG, OPMODEREG, 1: stage register enables.
- CARRYINSEL, "OPMODE5": carry source, "OPMODE5" or "CARRYIN".
- B_INPUT, "DIRECT": B source, "DIRECT" = B, "CASCADE" = BCIN.
- RSTTYPE, "SYNC": RSTx clears are "SYNC" or "ASYNC".

Ports:
- CLK  in  1  sole clock, rising edge.
- RST_N  in  1  global reset, asynchronous, active-low. Clears every register to 0. Declared as the last port.
- A, B, D, BCIN  in  18  operands.
- C, PCIN  in  48  post-adder operand / cascade input.
- CARRYIN  in  1  external carry.
- OPMODE  in  8  operation select.
- RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE  in  1  per-stage clears, active-high, to 0.
- CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, COPMODE  in  1  per-stage clock enables.
- BCOUT  out  18  B1-stage output.
- PCOUT, P  out  48  result.
- M  out  36  M-stage output.
- CARRYOUT, CARRYOUTF  out  1  post-adder carry. The two outputs are identical.
- Port order: A, B, C, D, CLK, CARRYIN, OPMODE, BCIN, RSTA, RSTB, RSTM, RSTP, RSTC, RSTD, RSTCARRYIN, RSTOPMODE, CEA, CEB, CEM, CEP, CEC, CED, CECARRYIN, COPMODE, PCIN, BCOUT, PCOUT, P, M, CARRYOUT, CARRYOUTF, RST_N.

## Operation
- Register priority: RST_N, then RSTx, then CE. A register with CE low holds its value.
- Register grouping:
  - A0 and A1 use RSTA/CEA.
  - B0 and B1 use RSTB/CEB.
  - The OPMODE register uses RSTOPMODE/COPMODE.
  - The carry-in and carry-out registers use RSTCARRYIN/CECARRYIN.
  - P uses RSTP/CEP.
- All OPMODE bits below are taken from the OPMODE stage output.
- Pre-adder:
  - b0 = B0 stage of (B_INPUT=="CASCADE" ? BCIN : B).
  - pre = OPMODE[6] ? d − b0 : d + b0, truncated to 18 bits.
  - B1 stage input = OPMODE[4] ? pre : b0.
  - BCOUT = B1 output.
- Multiplier: M stage input = B1 × A1, 36-bit, unsigned.
- X mux on OPMODE[1:0]:
  - 0: zero.
  - 1: M, zero-extended.
  - 2: P.
  - 3: {d[11:0], A1, B1}.
- Z mux on OPMODE[3:2]:
  - 0: zero.
  - 1: PCIN.
  - 2: P.
  - 3: registered C.
- Carry-in stage input = (CARRYINSEL=="OPMODE5" ? OPMODE[5] : CARRYIN). The carry-in stage output is cin.
- Post-adder, computed at 49 bits:
  - OPMODE[7]=0: Z + X + cin.
  - OPMODE[7]=1: Z − (X + cin).
- Post-adder outputs:
  - Bits [47:0] feed the P stage.
  - Bit 48 feeds the CARRYOUT stage.
  - PCOUT = P.

## Timing
- Reset value of every output is 0 (BCOUT, M, P, PCOUT, CARRYOUT, CARRYOUTF).
- Latency with default parameters:
  - A to P: 3 edges (A1, M, P).
  - B to P: 3 edges.
  - D to P: 4 edges.
  - OPMODE to effect: 1 edge.
- With a *REG parameter set to 0, that stage is a wire and contributes no latency.
- Simultaneous RSTx and CE: the clear wins.
- RST_N asserted mid-operation clears all registers immediately, without waiting for a clock edge.
- Feedback of P through X or Z uses the registered P value (PREG=1).

## Configuration
- DSP48A1_SIGNED_MULT_EN:
  - Defined: the multiplier treats A1 and B1 as two's complement, and M is sign-extended into X.
  - Undefined: the multiplier is unsigned and M is zero-extended.

## Test plan
- Clear: hold all RSTx=1 with A=10, B=15, C=12, D=3, PCIN=40, OPMODE=0x35 for 10 cycles -> P, M, BCOUT and CARRYOUT are 0 throughout.
- Pipeline: release the clears with COPMODE=1 and all CE=1. Expected P sequence after release: 0, 40, 191, then steady 221. Steady values: M=180, BCOUT=18, CARRYOUT=0.
- Accumulate: change OPMODE to 0x3E from that state -> one edge later, P increases by 13 (C + P + 1) every cycle: 234, 247, …
- Async reset: drop RST_N mid-accumulation between clock edges -> all outputs are 0 before the next edge.
- Cascade/subtract: B_INPUT="CASCADE", BCIN=100, D=3, OPMODE[6]=1, OPMODE[4]=1 -> BCOUT = (3 − 100) mod 2^18 = 0x3FF9F.
- Clock enable: CEP=0 for 3 cycles during accumulation -> P holds its value, then resumes incrementing by 13.
